imem_loader: RTL
================

# imem_loader

Boot-time program loader for the single-cycle processor's instruction memory. It receives a program as a little-endian byte stream over a valid/ready handshake and assembles 16-bit instruction words. It writes the words to consecutive instruction-memory addresses starting at 0, then checks a trailing 16-bit checksum. The core is held in reset (Cpu_Hold) until the load completes.

## Interface
- ADDR_W, 10, instruction-memory address width; depth = 2^ADDR_W words
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous, active-high reset
- Start  in  1  begins a load; sampled only in IDLE or DONE
- Length  in  ADDR_W+1  number of words to load; captured on accepted Start; values > 2^ADDR_W clamp to 2^ADDR_W
- Byte_In  in  8  stream data
- Byte_Valid  in  1  stream data valid
- Byte_Ready  out  1  loader accepts a byte this cycle
- Mem_Addr  out  ADDR_W  write address to instruction memory
- Mem_Data  out  16  write data
- Mem_WE  out  1  write strobe; memory writes at the rising edge closing a cycle with Mem_WE=1
- Cpu_Hold  out  1  holds the core in reset while high
- Busy  out  1  load in progress
- Done  out  1  last load finished; Error valid
- Error  out  1  checksum mismatch on the last load

## Operation
- States: IDLE, LO, HI, WRITE, CK_LO, CK_HI, DONE.
- IDLE/DONE + Start: capture Length, clear word counter and checksum accumulator → LO (→ CK_LO if Length=0).
- A byte transfers on a rising edge with Byte_Valid=1 and Byte_Ready=1. Byte_Ready=1 only in LO, HI, CK_LO, CK_HI.
- LO: transfer stores Byte_In as data[7:0] → HI. HI: transfer stores data[15:8] → WRITE.
- WRITE, one cycle: Mem_WE=1, Mem_Addr=word counter, Mem_Data=assembled word. The accumulator adds the word mod 2^16. If counter = Length−1 → CK_LO; else counter+1 → LO.
- CK_LO/CK_HI: receive the expected checksum, low byte first. The CK_HI transfer goes to DONE and registers Error = (received ≠ accumulator).
- DONE: Done=1, Busy=0, Cpu_Hold=0. Stays until the next Start, which clears Done and Error and restarts.
- Start in LO/HI/WRITE/CK_LO/CK_HI is ignored.
- Outside WRITE: Mem_WE=0, Mem_Addr=counter, Mem_Data=last assembled word.
- Busy=1 in every state except IDLE and DONE. Cpu_Hold=1 in every state except DONE.
- Word counter never exceeds 2^ADDR_W−1. For Length=2^ADDR_W the final write is at address 2^ADDR_W−1, with no wrap to 0.

## Timing
- Reset values: state IDLE, Byte_Ready=0, Mem_WE=0, Mem_Addr=0, Mem_Data=0, Busy=0, Done=0, Error=0, Cpu_Hold=1.
- Rst acts immediately (asynchronously). A load cut off mid-way is abandoned. Words already written stay in memory; no further writes occur.
- Outputs are decoded from registered state and registers, with no combinational path from Byte_Valid or Start to any output.
- Minimum 3 cycles per word (LO, HI, WRITE) with Byte_Valid held high.
- Minimum total load time after Start: 3·Length + 2 cycles. Done rises the cycle after the CK_HI transfer.
- Byte_Valid low stalls the current state indefinitely, with no timeout.

## Test plan
- Reset: assert Rst asynchronously mid-cycle → all outputs take their reset values immediately, Cpu_Hold=1.
- Good load: Length=3, bytes 34 12 CD AB 01 00 02 BE with Valid held high → writes 0x1234@0, 0xABCD@1, 0x0001@2, each with a one-cycle Mem_WE. Done=1 and Error=0 at cycle 11 after Start, Cpu_Hold=0.
- Bad checksum: same stream ending in 03 BE → all three writes still occur; Done=1, Error=1.
- Backpressure and ignored Start: Length=2, random Byte_Valid gaps, plus a Start pulse while Busy → correct data at addresses 0–1; Length is not re-captured; Done only after the checksum is received.
- Boundaries:
  - Length=0 with bytes 00 00 → no Mem_WE; Done=1, Error=0.
  - Length=1024 → last write at address 1023; exactly 1024 Mem_WE pulses.
- Reset mid-load: Rst after the first word is written → IDLE immediately. A new Start with Length=1 and bytes EF BE EF BE → 0xBEEF@0, Error=0.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles little-endian byte pairs into
// 16-bit words, writes them from address 0 upward, then verifies a 16-bit checksum.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   length_i,
    input  logic [7:0]        byte_in_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [15:0]       mem_data_o,
    output logic              mem_we_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    typedef enum logic [2:0] {
        IDLE, LO, HI, WRITE, CK_LO, CK_HI, DONE
    } state_t;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [7:0]        lo_q, lo_d;
    logic [15:0]       data_q, data_d;
    logic [15:0]       acc_q, acc_d;
    logic [7:0]        ck_lo_q, ck_lo_d;
    logic              err_q, err_d;
    logic              byteReady;
    logic              xfer;
    logic [ADDR_W:0]   lenClamped;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            lo_q    <= '0;
            data_q  <= '0;
            acc_q   <= '0;
            ck_lo_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            lo_q    <= lo_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
            ck_lo_q <= ck_lo_d;
            err_q   <= err_d;
        end
    end

    assign byteReady  = (state_q == LO) || (state_q == HI) ||
                        (state_q == CK_LO) || (state_q == CK_HI);
    assign xfer       = byteReady && byte_valid_i;
    assign lenClamped = (length_i > MAX_LEN) ? MAX_LEN : length_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        lo_d    = lo_q;
        data_d  = data_q;
        acc_d   = acc_q;
        ck_lo_d = ck_lo_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    len_d   = lenClamped;
                    cnt_d   = '0;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    state_d = (lenClamped == '0) ? CK_LO : LO;
                end
            end
            LO: begin
                if (xfer) begin
                    lo_d    = byte_in_i;
                    state_d = HI;
                end
            end
            HI: begin
                if (xfer) begin
                    data_d  = {byte_in_i, lo_q};
                    state_d = WRITE;
                end
            end
            WRITE: begin
                acc_d = acc_q + data_q;
                // Stop at Length-1 so a full-depth load never wraps the address back to 0.
                if ({1'b0, cnt_q} == len_q - ONE) begin
                    state_d = CK_LO;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = LO;
                end
            end
            CK_LO: begin
                if (xfer) begin
                    ck_lo_d = byte_in_i;
                    state_d = CK_HI;
                end
            end
            CK_HI: begin
                if (xfer) begin
                    err_d   = ({byte_in_i, ck_lo_q} != acc_q);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_ready_o = byteReady;
    assign mem_we_o     = (state_q == WRITE);
    assign mem_addr_o   = cnt_q;
    assign mem_data_o   = data_q;
    assign busy_o       = (state_q != IDLE) && (state_q != DONE);
    assign cpu_hold_o   = (state_q != DONE);
    assign done_o       = (state_q == DONE);
    assign error_o      = err_q;

endmodule
